// File: rtl/lc3b_pkg.sv
// lc3b_pkg -- shared types and constants for the LC-3b memory stage.
//   mem_state_t : controller FSM states
//   SIZE_* / RW_*: encodings of DATA_SIZE and R_W
//   NUM_LANES/VEC_W: memory organised as two byte lanes per 16-bit word
//   fmt_mdr()   : byte steering + sign extension for the GateMDR path
package lc3b_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} mem_state_t;

  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;
  localparam logic RW_READ   = 1'b0;
  localparam logic RW_WRITE  = 1'b1;

  localparam int NUM_LANES = 2;
  localparam int VEC_W     = 8;

  // Word: pass through. Byte: pick the lane named by a0, sign-extend.
  function automatic logic [15:0] fmt_mdr(input logic [15:0] mdr,
                                          input logic        a0,
                                          input logic        size);
    logic [7:0] b;
    b = a0 ? mdr[15:8] : mdr[7:0];
    return (size == SIZE_WORD) ? mdr : {{8{b[7]}}, b};
  endfunction

endpackage

// File: rtl/lc3b_mem_ctrl_if.sv
// lc3b_mem_ctrl_if -- datapath <-> memory-stage signal bundle.
//   master: datapath/microsequencer side (drives MAR, BUS_IN, LD_MDR,
//           MIO_EN, R_W, DATA_SIZE; observes MDR_OUT, R, MEM_BUSY, UNALIGNED)
//   slave : memory controller side (mirror directions)
interface lc3b_mem_ctrl_if;
  logic [15:0] MAR;
  logic [15:0] BUS_IN;
  logic        LD_MDR;
  logic        MIO_EN;
  logic        R_W;
  logic        DATA_SIZE;
  logic [15:0] MDR_OUT;
  logic        R;
  logic        MEM_BUSY;
  logic        UNALIGNED;

  modport master (output MAR, BUS_IN, LD_MDR, MIO_EN, R_W, DATA_SIZE,
                  input  MDR_OUT, R, MEM_BUSY, UNALIGNED);
  modport slave  (input  MAR, BUS_IN, LD_MDR, MIO_EN, R_W, DATA_SIZE,
                  output MDR_OUT, R, MEM_BUSY, UNALIGNED);
endinterface

// File: rtl/lc3b_mem_array.sv
// lc3b_mem_array -- 2**AW x (NUM_LANES*VEC_W) RAM, one storage column per
// byte lane. Synchronous write with per-lane enable, asynchronous read,
// no reset (contents survive RESET).
//   CLK   : write clock
//   waddr : word address (shared by read and write)
//   we    : per-lane write enable
//   wdata : write data, lane-packed
//   rdata : read data, lane-packed
module lc3b_mem_array
  import lc3b_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic                              CLK,
  input  logic [AW-1:0]                     waddr,
  input  logic [NUM_LANES-1:0]              we,
  input  logic [NUM_LANES-1:0][VEC_W-1:0]   wdata,
  output logic [NUM_LANES-1:0][VEC_W-1:0]   rdata
);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic [VEC_W-1:0] mem [2**AW];

    always_ff @(posedge CLK) begin
      if (we[g]) mem[waddr] <= wdata[g];
    end

    assign rdata[g] = mem[waddr];
  end

endmodule

// File: rtl/lc3b_mem_ctrl.sv
// lc3b_mem_ctrl -- LC-3b memory stage: owns MDR and a fixed-latency,
// byte-addressed, word-organised memory.
//   CLK   : rising-edge clock
//   RESET : asynchronous, active-low reset
//   bus   : lc3b_mem_ctrl_if.slave
//     in : MAR, BUS_IN, LD_MDR, MIO_EN, R_W, DATA_SIZE
//     out: MDR_OUT (formatted for GateMDR), R (1-cycle ready pulse),
//          MEM_BUSY (in ACCESS), UNALIGNED
// Build option: LC3B_UNALIGNED_TRAP_EN -- word access at an odd address
//   pulses UNALIGNED with R and suppresses the write. Without it,
//   UNALIGNED is 0 and odd word accesses silently align down.
module lc3b_mem_ctrl
  import lc3b_pkg::*;
#(
  parameter int MEM_LATENCY = 5,   // 1..15
  parameter int MEM_AW      = 12
) (
  input  logic            CLK,
  input  logic            RESET,
  lc3b_mem_ctrl_if.slave  bus
);

  mem_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q;
  logic        size_q;
  logic        rw_q;
  logic [15:0] mdr_q, mdr_d;
  logic        mdr_en;
  logic        start;
  logic        fire;        // access edge: R high this cycle
  logic        unal_hit;
  logic        wr_go;

  logic [NUM_LANES-1:0]            mem_we;
  logic [NUM_LANES-1:0][VEC_W-1:0] rdata;
  logic [15:0]                     rd_word;

  logic unused_addr;
  assign unused_addr = ^addr_q;

  // ---------------- state register ----------------
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      size_q  <= 1'b0;
      rw_q    <= 1'b0;
      mdr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (start) begin
        addr_q <= bus.MAR;
        size_q <= bus.DATA_SIZE;
        rw_q   <= bus.R_W;
      end
      if (mdr_en) mdr_q <= mdr_d;
    end
  end

  // ---------------- next state ----------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start   = 1'b0;
    fire    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.MIO_EN) begin
          state_d = ACCESS;
          cnt_d   = 4'd1;
          start   = 1'b1;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'(MEM_LATENCY)) begin
          fire    = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        // Wait for the sequencer to drop MIO_EN so one request = one access.
        if (!bus.MIO_EN) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- write enables ----------------
  assign unal_hit = fire && (size_q == SIZE_WORD) && addr_q[0];

`ifdef LC3B_UNALIGNED_TRAP_EN
  assign wr_go = fire && (rw_q == RW_WRITE) && !unal_hit;
`else
  assign wr_go = fire && (rw_q == RW_WRITE);
`endif

  // Byte store writes only the lane named by addr[0]; MDR already holds
  // the byte replicated in both halves, so wdata needs no steering.
  assign mem_we[1] = wr_go && (size_q | addr_q[0]);
  assign mem_we[0] = wr_go && (size_q | ~addr_q[0]);

  lc3b_mem_array #(.AW(MEM_AW)) u_mem (
    .CLK   (CLK),
    .waddr (addr_q[MEM_AW:1]),
    .we    (mem_we),
    .wdata (mdr_q),
    .rdata (rdata)
  );

  assign rd_word = rdata;

  // ---------------- MDR load ----------------
  // Memory data wins at the access edge; bus loads only when no request
  // is outstanding, so LD_MDR held through an access just holds MDR.
  always_comb begin
    mdr_en = 1'b0;
    mdr_d  = mdr_q;
    if (fire && (rw_q == RW_READ) && bus.LD_MDR) begin
      mdr_en = 1'b1;
      mdr_d  = rd_word;
    end else if (bus.LD_MDR && !bus.MIO_EN) begin
      mdr_en = 1'b1;
      mdr_d  = (bus.DATA_SIZE == SIZE_BYTE) ? {2{bus.BUS_IN[7:0]}} : bus.BUS_IN;
    end
  end

  // ---------------- outputs ----------------
  // Formatting follows the live MAR/DATA_SIZE, not the latched copies.
  assign bus.MDR_OUT  = fmt_mdr(mdr_q, bus.MAR[0], bus.DATA_SIZE);
  assign bus.R        = fire;
  assign bus.MEM_BUSY = (state_q == ACCESS);

`ifdef LC3B_UNALIGNED_TRAP_EN
  assign bus.UNALIGNED = unal_hit;
`else
  assign bus.UNALIGNED = 1'b0;
`endif

endmodule

// File: tb/tb_lc3b_mem_ctrl.sv
// tb_lc3b_mem_ctrl -- self-checking bench for lc3b_mem_ctrl. Keeps a
// shadow memory/MDR model; read expectations are queued when a request is
// issued and popped when the access completes.
module tb_lc3b_mem_ctrl;

  localparam int LAT = 5;

  logic CLK   = 1'b0;
  logic RESET = 1'b0;

  lc3b_mem_ctrl_if bus ();

  lc3b_mem_ctrl #(.MEM_LATENCY(LAT), .MEM_AW(12)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;

  logic [15:0] mem_m [int];
  logic [15:0] mdr_m = 16'h0;
  logic [15:0] exp_q [$];

  always @(posedge CLK) if (RESET && (|dut.mem_we)) wr_cnt++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic int wa(input logic [15:0] mar);
    return int'(mar[12:1]);
  endfunction

  function automatic logic [15:0] fmt(input logic [15:0] w, input logic a0, input logic word);
    logic [7:0] b;
    b = a0 ? w[15:8] : w[7:0];
    if (word) return w;
    return {{8{b[7]}}, b};
  endfunction

  function automatic bit trap_on();
`ifdef LC3B_UNALIGNED_TRAP_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic load_mdr(input logic [15:0] v, input bit word);
    logic [15:0] e;
    @(negedge CLK);
    bus.BUS_IN = v; bus.DATA_SIZE = word; bus.LD_MDR = 1'b1; bus.MIO_EN = 1'b0;
    @(negedge CLK);
    bus.LD_MDR = 1'b0;
    mdr_m = word ? v : {v[7:0], v[7:0]};
    e = fmt(mdr_m, bus.MAR[0], word);
    checks++;
    if (bus.MDR_OUT !== e) begin
      errors++;
      $display("FAIL load_mdr: MDR_OUT=%h expected %h", bus.MDR_OUT, e);
    end
  endtask

  // One full request: issue, wait for R, optional MAR glitch, hold extra cycles.
  task automatic access(input logic [15:0] mar, input bit wr, input bit word,
                        input bit ld, input int hold, input bit glitch);
    int cyc, rcnt, w0, nwr, k;
    bit unal;
    logic [15:0] old, e;
    @(negedge CLK);
    bus.MAR = mar; bus.R_W = wr; bus.DATA_SIZE = word; bus.LD_MDR = ld; bus.MIO_EN = 1'b1;
    w0   = wr_cnt;
    k    = wa(mar);
    unal = trap_on() && word && mar[0];
    if (!wr) begin
      if (ld) mdr_m = mem_m[k];
      exp_q.push_back(fmt(mdr_m, mar[0], word));
    end
    cyc = 0;
    do begin
      @(negedge CLK);
      cyc++;
      if (glitch && cyc == 2) bus.MAR = ~mar;
    end while (bus.R !== 1'b1 && cyc < 40);
    checks++;
    if (cyc != LAT) begin
      errors++;
      $display("FAIL latency %h: R after %0d cycles expected %0d", mar, cyc, LAT);
    end
    checks++;
    if (bus.UNALIGNED !== unal) begin
      errors++;
      $display("FAIL unaligned %h: UNALIGNED=%b expected %b", mar, bus.UNALIGNED, unal);
    end
    bus.MAR = mar;
    nwr = 0;
    if (wr && !unal) begin
      nwr = 1;
      old = mem_m.exists(k) ? mem_m[k] : 16'h0;
      if (word || mar[0])  old[15:8] = mdr_m[15:8];
      if (word || !mar[0]) old[7:0]  = mdr_m[7:0];
      mem_m[k] = old;
    end
    @(negedge CLK);
    rcnt = 0;
    for (int i = 0; i < hold; i++) begin
      if (bus.R !== 1'b0 || bus.MEM_BUSY !== 1'b0) rcnt++;
      @(negedge CLK);
    end
    checks++;
    if (rcnt != 0) begin
      errors++;
      $display("FAIL hold %h: %0d extra R/BUSY cycles expected 0", mar, rcnt);
    end
    checks++;
    if (wr_cnt - w0 != nwr) begin
      errors++;
      $display("FAIL write_count %h: %0d writes expected %0d", mar, wr_cnt - w0, nwr);
    end
    if (!wr) begin
      e = exp_q.pop_front();
      checks++;
      if (bus.MDR_OUT !== e) begin
        errors++;
        $display("FAIL read %h: MDR_OUT=%h expected %h", mar, bus.MDR_OUT, e);
      end
    end
    bus.MIO_EN = 1'b0; bus.LD_MDR = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    bus.MAR = 16'h0; bus.BUS_IN = 16'h0; bus.LD_MDR = 1'b0; bus.MIO_EN = 1'b0;
    bus.R_W = 1'b0; bus.DATA_SIZE = 1'b1;
    RESET = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if (bus.R !== 1'b0 || bus.MEM_BUSY !== 1'b0 || bus.UNALIGNED !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: R/BUSY/UNAL=%b%b%b expected 000", bus.R, bus.MEM_BUSY, bus.UNALIGNED);
    end
    checks++;
    if (bus.MDR_OUT !== 16'h0) begin
      errors++;
      $display("FAIL reset_mdr: MDR_OUT=%h expected 0000", bus.MDR_OUT);
    end
    RESET = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_word_write_read();
    load_mdr(16'h1234, 1'b1);
    access(16'h3000, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    access(16'h3000, 1'b0, 1'b1, 1'b1, 0, 1'b0);
    access(16'h1000, 1'b0, 1'b1, 1'b1, 0, 1'b0);   // aliases x3000
  endtask

  task automatic test_reset_mid_access();
    int w0, rp;
    load_mdr(16'hBEEF, 1'b1);
    w0 = wr_cnt;
    rp = 0;
    @(negedge CLK);
    bus.MAR = 16'h3000; bus.R_W = 1'b1; bus.DATA_SIZE = 1'b1; bus.MIO_EN = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      if (bus.R !== 1'b0) rp++;
    end
    RESET = 1'b0;
    #1;
    checks++;
    if (bus.MEM_BUSY !== 1'b0 || bus.MDR_OUT !== 16'h0) begin
      errors++;
      $display("FAIL reset_mid: BUSY=%b MDR_OUT=%h expected 0 0000", bus.MEM_BUSY, bus.MDR_OUT);
    end
    bus.MIO_EN = 1'b0;
    repeat (4) begin
      @(negedge CLK);
      if (bus.R !== 1'b0) rp++;
    end
    RESET = 1'b1;
    mdr_m = 16'h0;
    repeat (2) begin
      @(negedge CLK);
      if (bus.R !== 1'b0) rp++;
    end
    checks++;
    if (rp != 0 || wr_cnt != w0) begin
      errors++;
      $display("FAIL reset_abort: R pulses=%0d writes=%0d expected 0 0", rp, wr_cnt - w0);
    end
    access(16'h3000, 1'b0, 1'b1, 1'b1, 0, 1'b0);   // still 1234
  endtask

  task automatic test_byte_store();
    bus.MAR = 16'h3001;
    load_mdr(16'h00A5, 1'b0);
    access(16'h3001, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    access(16'h3001, 1'b0, 1'b0, 1'b1, 0, 1'b0);   // FFA5
    access(16'h3000, 1'b0, 1'b1, 1'b1, 0, 1'b0);   // A534
  endtask

  task automatic test_byte_read();
    load_mdr(16'h8070, 1'b1);
    access(16'h3000, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    access(16'h3000, 1'b0, 1'b0, 1'b1, 0, 1'b0);   // 0070
    access(16'h3001, 1'b0, 1'b0, 1'b1, 0, 1'b0);   // FF80
    access(16'h3002, 1'b0, 1'b0, 1'b0, 0, 1'b0);   // no LD_MDR: MDR holds
  endtask

  task automatic test_back_to_back();
    load_mdr(16'h7777, 1'b1);
    access(16'h3006, 1'b1, 1'b1, 1'b0, 3, 1'b1);
    access(16'h3006, 1'b0, 1'b1, 1'b1, 3, 1'b1);
  endtask

  task automatic test_odd_word();
    load_mdr(16'h5A5A, 1'b1);
    access(16'h3002, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    load_mdr(16'hCAFE, 1'b1);
    access(16'h3003, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    access(16'h3002, 1'b0, 1'b1, 1'b1, 0, 1'b0);
    access(16'h3003, 1'b0, 1'b1, 1'b1, 0, 1'b0);   // read aligns down
  endtask

  initial begin
    test_reset();
    test_word_write_read();
    test_reset_mid_access();
    test_byte_store();
    test_byte_read();
    test_back_to_back();
    test_odd_word();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d entries left expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
